// File: rtl/sub_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sub_serial_pkg
//  Purpose : Shared types and constants for the bit-serial subtractor.
//            Holds the FSM state encoding and the default operand width.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package sub_serial_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : sub_serial_pkg
`default_nettype wire

// File: rtl/serial_sub_cell.sv
`default_nettype none
// ============================================================================
//  Module  : serial_sub_cell
//  Purpose : Combinational one-bit full subtractor (a - b - borrow_in).
//  Ports   : a_bit_i  - minuend bit
//            b_bit_i  - subtrahend bit
//            bin_i    - borrow in
//            d_o      - difference bit
//            bout_o   - borrow out
//  Rev     : 1.0  initial release
// ============================================================================
module serial_sub_cell (
   input  logic a_bit_i,
   input  logic b_bit_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   logic w_axb;

   assign w_axb  = a_bit_i ^ b_bit_i;
   assign d_o    = w_axb ^ bin_i;
   // Borrow when a=0,b=1, or when the bits are equal and a borrow is pending.
   assign bout_o = (~a_bit_i & b_bit_i) | (~w_axb & bin_i);

endmodule : serial_sub_cell
`default_nettype wire

// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
//  Module  : sub_serial
//  Purpose : Bit-serial subtractor, out = a - b (mod 2^WIDTH), LSB first,
//            one bit per clock. Operands load on en in IDLE, the result is
//            shifted into out, then held with done until en is released.
//  Ports   : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            en         - start level (sampled in IDLE and DONE only)
//            a, b       - minuend / subtrahend, captured on the load edge
//            out        - difference register
//            borrow_out - final borrow (1 = a < b unsigned)
//            done       - high while in DONE
//  Rev     : 1.0  initial release
// ============================================================================
module sub_serial
   import sub_serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             borrow_out,
   output logic             done
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [CW-1:0]    count_q, count_d;
   logic             borrow_q, borrow_d;
   logic             borrow_out_q, borrow_out_d;
   logic             done_q, done_d;

   logic             w_diff;
   logic             w_bout;

   serial_sub_cell u_cell (
      .a_bit_i (a_q[0]),
      .b_bit_i (b_q[0]),
      .bin_i   (borrow_q),
      .d_o     (w_diff),
      .bout_o  (w_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         out_q        <= '0;
         count_q      <= '0;
         borrow_q     <= 1'b0;
         borrow_out_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         out_q        <= out_d;
         count_q      <= count_d;
         borrow_q     <= borrow_d;
         borrow_out_q <= borrow_out_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      out_d        = out_q;
      count_d      = count_q;
      borrow_d     = borrow_q;
      borrow_out_d = borrow_out_q;
      done_d       = done_q;

      case (state_q)
         IDLE: begin
            if (en) begin
               a_d      = a;
               b_d      = b;
               borrow_d = 1'b0;
               count_d  = '0;
               out_d    = '0;
               done_d   = 1'b0;
               state_d  = SUB;
            end
         end

         SUB: begin
            // Result bits enter at the MSB so the LSB-first stream lands aligned.
            out_d    = {w_diff, out_q[WIDTH-1:1]};
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            borrow_d = w_bout;
            if (count_q == CW'(WIDTH - 1)) begin
               // Last bit: hold the counter at its terminal value.
               state_d      = DONE;
               done_d       = 1'b1;
               borrow_out_d = w_bout;
            end else begin
               count_d = count_q + CW'(1);
            end
         end

         DONE: begin
            // Leaving needs en low, so a held en cannot retrigger.
            if (!en) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign out        = out_q;
   assign borrow_out = borrow_out_q;
   assign done       = done_q;

endmodule : sub_serial
`default_nettype wire

// File: tb/tb_sub_serial.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sub_serial
//  Purpose : Self-checking bench for sub_serial (WIDTH=8). Stimulus pushes
//            expected results into a queue; a monitor pops one on each
//            rising done and checks value, borrow and latency.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sub_serial;

   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] exp_out;
      logic             exp_borrow;
      int               exp_cyc;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] out;
   logic             borrow_out;
   logic             done;

   exp_t exp_q[$];
   int   checks;
   int   failures;
   int   cyc;
   logic done_prev;

   sub_serial #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .a          (a),
      .b          (b),
      .out        (out),
      .borrow_out (borrow_out),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         failures = failures + 1;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor: one scoreboard entry per rising done.
   always @(negedge clk) begin
      if (!rst_n) begin
         done_prev = 1'b0;
      end else begin
         if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
               checks   = checks + 1;
               failures = failures + 1;
               $display("FAIL unexpected_done actual=1 required=0 out=0x%0h", out);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("mon_out", 32'(out), 32'(e.exp_out));
               check("mon_borrow", 32'(borrow_out), 32'(e.exp_borrow));
               check("mon_latency", 32'(cyc), 32'(e.exp_cyc));
            end
         end
         done_prev = done;
      end
   end

   // Load on the next edge; en held for hold extra cycles after done.
   task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic [WIDTH-1:0] eo, input logic eb,
                         input bit scramble, input int hold);
      exp_t e;
      bit   seen;
      @(negedge clk);
      a  = av;
      b  = bv;
      en = 1'b1;
      e.exp_out    = eo;
      e.exp_borrow = eb;
      e.exp_cyc    = cyc + 1 + WIDTH;
      exp_q.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (scramble) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
         end
         if (hold == 0) en = 1'b0;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL done_timeout actual=0 required=1");
      end
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check("done_held", 32'(done), 32'd1);
         check("out_held", 32'(out), 32'(eo));
         en = 1'b0;
      end
      @(negedge clk);
      check("done_fall", 32'(done), 32'd0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      done_prev = 1'b0;
      rst_n     = 1'b0;
      en        = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(negedge clk);
      check("rst_out", 32'(out), 32'd0);
      check("rst_borrow", 32'(borrow_out), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;

      run_op(8'h5A, 8'h33, 8'h27, 1'b0, 1'b0, 0);
      run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0);
      run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0);
      run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 0);
      run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 0);
      run_op(8'h77, 8'h12, 8'h65, 1'b0, 1'b1, 0);

      // en held 30 cycles: exactly one operation, then release.
      run_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 30);
      repeat (2) @(negedge clk);
      check("idle_out_hold", 32'(out), 32'h05);
      check("idle_borrow_hold", 32'(borrow_out), 32'd0);

      // Async reset in the middle of an operation.
      @(negedge clk);
      a  = 8'h5A;
      b  = 8'h33;
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_out", 32'(out), 32'd0);
      check("async_borrow", 32'(borrow_out), 32'd0);
      check("async_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h03, 8'h02, 8'h01, 1'b0, 1'b0, 0);

      // Back-to-back with a short en gap.
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 0);
      run_op(8'h01, 8'h80, 8'h81, 1'b1, 1'b0, 0);

      repeat (3) @(negedge clk);
      check("pending_results", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sub_serial
`default_nettype wire
